seg7_scan_controller: RTL and testbench



---
 rtl/seg7_scan_controller_pkg.sv | 23 ++
 rtl/seg7_scan_controller_scan_tick_gen.sv | 32 +++
 rtl/seg7_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_controller_pkg.sv
// rtl/seg7_scan_controller_pkg.sv - shared types and helpers for the 7-segment scan controller
package seg7_scan_controller_pkg;

    // Width of one BCD/hex digit field in the display word
    localparam int DIGIT_W = 4;

    // Scan slot phases: all-off guard, then the digit is lit
    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Bits needed to index n items, never less than one bit
    function automatic int seg7_clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_scan_tick_gen.sv
// rtl/seg7_scan_controller_scan_tick_gen.sv - prescaler producing one-clock scan ticks
module scan_tick_gen
    import seg7_scan_controller_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W   = seg7_clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick on the last count of each period; suppressed while held clear
    assign tick = !clear && (cnt_q == CNT_MAX);

    // Free-running modulo-PRESCALE counter, parked at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed 7-segment digit scanner with shadowed display word
module seg7_scan_controller
    import seg7_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int DWELL_TICKS = 4,
    parameter int GUARD_TICKS = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                lzb_en,
    input  logic                                load_valid,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]       load_data,
    output logic                                load_ready,
    output logic [DIGIT_W-1:0]                  dec_nibble,
    output logic [NUM_DIGITS-1:0]               digit_an_n,
    output logic [seg7_clog2(NUM_DIGITS)-1:0]   cur_digit,
    output logic                                frame_done
);

    localparam int WORD_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = seg7_clog2(NUM_DIGITS);
    localparam int MAX_T  = (DWELL_TICKS > GUARD_TICKS) ? DWELL_TICKS : GUARD_TICKS;
    localparam int TCNT_W = seg7_clog2(MAX_T + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TCNT_W-1:0] GUARD_LAST = TCNT_W'(GUARD_TICKS - 1);
    localparam logic [TCNT_W-1:0] DWELL_LAST = TCNT_W'(DWELL_TICKS - 1);

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                wrap;
    logic                tick;

    logic [WORD_W-1:0]   active_q, active_d;
    logic [WORD_W-1:0]   shadow_q;
    logic                shadow_full_q;
    logic                commit;
    logic                accept;

    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] an_d;
    logic [DIGIT_W-1:0]    nib_d;

    scan_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!enable),
        .tick  (tick)
    );

    // Pending word moves to the display at a frame wrap, or at once while scanning is stopped
    assign accept     = load_valid && !shadow_full_q;
    assign commit     = shadow_full_q && (wrap || !enable);
    assign active_d   = commit ? shadow_q : active_q;
    assign load_ready = !shadow_full_q;
    assign cur_digit  = idx_q;

    // Display word and single-entry shadow holding the next word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            active_q <= active_d;
            if (commit) begin
                shadow_q      <= '0;
                shadow_full_q <= 1'b0;
            end else if (accept) begin
                shadow_q      <= load_data;
                shadow_full_q <= 1'b1;
            end
        end
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GUARD;
            idx_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Slot sequencing: guard then show per digit, stepping only on ticks
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        wrap    = 1'b0;
        if (!enable) begin
            state_d = ST_GUARD;
            idx_d   = '0;
            tcnt_d  = '0;
        end else if (tick) begin
            case (state_q)
                ST_GUARD: begin
                    if (tcnt_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (tcnt_q == DWELL_LAST) begin
                        state_d = ST_GUARD;
                        tcnt_d  = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_GUARD;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Next output values, derived from the upcoming slot and the word it will display
    always_comb begin
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero && (active_d[i*DIGIT_W +: DIGIT_W] == '0);
            blank_mask[i] = lzb_en && (i != 0) && upper_zero;
        end
        an_d = '1;
        if ((state_d == ST_SHOW) && !blank_mask[idx_d]) begin
            an_d[idx_d] = 1'b0;
        end
        nib_d = active_d[int'(idx_d)*DIGIT_W +: DIGIT_W];
    end

    // Registered outputs so the pads never see combinational glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_an_n <= '1;
            dec_nibble <= '0;
            frame_done <= 1'b0;
        end else begin
            digit_an_n <= an_d;
            dec_nibble <= nib_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - randomized self-checking bench for seg7_scan_controller
module tb_seg7_scan_controller;

    localparam int ND       = 4;
    localparam int PS       = 2;
    localparam int DW       = 3;
    localparam int GT       = 1;
    localparam int SLOT_CLK = (GT + DW) * PS;
    localparam int GUARD_CLK = GT * PS;
    localparam int FRAME    = ND * SLOT_CLK;
    localparam int NCYC     = 3000;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              lzb_en;
    logic              load_valid;
    logic [4*ND-1:0]   load_data;
    logic              load_ready;
    logic [3:0]        dec_nibble;
    logic [ND-1:0]     digit_an_n;
    logic [1:0]        cur_digit;
    logic              frame_done;

    int n_pass;
    int n_total;

    // Model state: position inside the current frame plus display/shadow contents
    int              m_p;
    logic [4*ND-1:0] m_active;
    logic [4*ND-1:0] m_shadow;
    bit              m_full;
    logic [ND-1:0]   e_an;
    logic [3:0]      e_dec;
    int              e_cur;
    bit              e_fd;

    int dis_left;
    bit rst_done;

    seg7_scan_controller #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (PS),
        .DWELL_TICKS (DW),
        .GUARD_TICKS (GT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lzb_en     (lzb_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .dec_nibble (dec_nibble),
        .digit_an_n (digit_an_n),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected registered outputs for a given frame position and display word
    task automatic model_outputs();
        int d;
        int w;
        bit blank;
        d     = m_p / SLOT_CLK;
        w     = m_p % SLOT_CLK;
        e_cur = d;
        e_dec = m_active[d*4 +: 4];
        blank = lzb_en && (d > 0) && ((m_active >> (4*d)) == 16'h0);
        e_an  = '1;
        if ((w >= GUARD_CLK) && !blank) begin
            e_an[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_p      = 0;
        m_active = '0;
        m_shadow = '0;
        m_full   = 0;
        e_an     = '1;
        e_dec    = '0;
        e_cur    = 0;
        e_fd     = 0;
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_step();
        bit acc;
        bit wrp;
        bit cmt;
        acc = load_valid && !m_full;
        wrp = enable && (m_p == FRAME - 1);
        cmt = m_full && (wrp || !enable);
        if (cmt) begin
            m_active = m_shadow;
            m_full   = 0;
        end else if (acc) begin
            m_shadow = load_data;
            m_full   = 1;
        end
        m_p  = enable ? (m_p + 1) % FRAME : 0;
        e_fd = wrp;
        model_outputs();
    endtask

    task automatic check_all();
        check("digit_an_n", 32'(digit_an_n), 32'(e_an));
        check("dec_nibble", 32'(dec_nibble), 32'(e_dec));
        check("cur_digit",  32'(cur_digit),  32'(e_cur));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_full));
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        dis_left   = 0;
        rst_done   = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        lzb_en     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            check_all();

            // One asynchronous reset pulse while a digit is lit, checked before any clock edge
            if (!rst_done && (c >= 1700) && (e_an != 4'hF)) begin
                rst_done = 1;
                #1 rst_n = 1'b0;
                #1;
                check("async_rst_an",    32'(digit_an_n), 32'hF);
                check("async_rst_ready", 32'(load_ready), 32'h1);
                check("async_rst_fd",    32'(frame_done), 32'h0);
                #1 rst_n = 1'b1;
                model_reset();
            end

            if (dis_left > 0) begin
                enable   = 1'b0;
                dis_left = dis_left - 1;
            end else begin
                enable = 1'b1;
                if ((c > 40) && ($urandom_range(0, 149) == 0)) begin
                    dis_left = $urandom_range(1, 12);
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                lzb_en = ~lzb_en;
            end
            if (c == 600) begin
                lzb_en = 1'b1;
            end
            load_valid = (c > 40) && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < ND; k++) begin
                load_data[k*4 +: 4] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            end

            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
